// File: rtl/lcd1602_text_buf_if.sv
// Write/clear bus into lcd1602_text_buf: one cell write per cycle, clear request
// pulse, and the busy status back to the bus side.
interface lcd1602_text_buf_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_req;
  logic       busy;

  modport master (output wr_en, output wr_addr, output wr_data, output clr_req, input busy);
  modport slave  (input wr_en, input wr_addr, input wr_data, input clr_req, output busy);
endinterface

// File: rtl/lcd1602_text_buf.sv
// 32-cell text frame buffer with dirty tracking; replays changed cells to lcd1602_ctrl
// as paced one-cycle pulses. Option macro: LCD1602_TEXT_BUF_SKIPCUR_EN (skip redundant cursor moves).
module lcd1602_text_buf #(
  parameter int unsigned GAP_CYCLES = 250010,
  parameter int unsigned CNT_W      = 18
) (
  input  logic              Clk,
  input  logic              Rst_n,
  lcd1602_text_buf_if.slave bus,
  input  logic              init_done,
  output logic [4:0]        Pos,
  output logic              Set_Cursor,
  output logic [7:0]        Data,
  output logic              Set_Data,
  output logic              Clr_Screen
);
  // state  | meaning
  // IDLE   | nothing to send, or controller not initialised
  // SCAN   | walk ptr looking for clear request or dirty cell
  // CLR    | Clr_Screen pulse, wipe buffer
  // CUR    | Set_Cursor pulse at ptr
  // DAT    | Set_Data pulse with buf[ptr]
  // WAIT   | pacing gap, then return target
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_CLR, S_CUR, S_DAT, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] GAP = CNT_W'(GAP_CYCLES);

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         ptr_q, ptr_d;
  logic [7:0]         buf_q [32];
  logic [7:0]         buf_d [32];
  logic [31:0]        dirty_q, dirty_d;
  logic               clr_pend_q, clr_pend_d;
  logic [4:0]         pos_q, pos_d;
  logic [7:0]         data_q, data_d;
  logic               set_cur_q, set_cur_d;
  logic               set_dat_q, set_dat_d;
  logic               clr_scr_q, clr_scr_d;
  logic               skip;
`ifdef LCD1602_TEXT_BUF_SKIPCUR_EN
  logic [4:0]         cur_pos_q, cur_pos_d;
  logic               cur_valid_q, cur_valid_d;
`endif

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    buf_d      = buf_q;
    dirty_d    = dirty_q;
    clr_pend_d = clr_pend_q;
    pos_d      = pos_q;
    data_d     = data_q;
    skip       = 1'b0;
`ifdef LCD1602_TEXT_BUF_SKIPCUR_EN
    cur_pos_d   = cur_pos_q;
    cur_valid_d = cur_valid_q;
    skip        = cur_valid_q && (cur_pos_q == ptr_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (init_done && (clr_pend_q || (|dirty_q))) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (clr_pend_q) begin
          state_d = S_CLR;
        end else if (dirty_q[ptr_q]) begin
          state_d = skip ? S_DAT : S_CUR;
        end else begin
          ptr_d = ptr_q + 5'd1;
          if (dirty_q == 32'd0) state_d = S_IDLE;
        end
      end
      S_CLR: begin
        for (int i = 0; i < 32; i++) buf_d[i] = 8'h20;
        dirty_d    = 32'd0;
        clr_pend_d = 1'b0;
`ifdef LCD1602_TEXT_BUF_SKIPCUR_EN
        cur_pos_d   = 5'd0;
        cur_valid_d = 1'b1;
`endif
        state_d = S_WAIT;
        ret_d   = S_SCAN;
        cnt_d   = GAP;
      end
      S_CUR: begin
        state_d = S_WAIT;
        ret_d   = S_DAT;
        cnt_d   = GAP;
      end
      S_DAT: begin
        dirty_d[ptr_q] = 1'b0;
`ifdef LCD1602_TEXT_BUF_SKIPCUR_EN
        // LCD DDRAM address does not run from column 15 into line 2
        if (ptr_q[3:0] != 4'hF) begin
          cur_pos_d   = ptr_q + 5'd1;
          cur_valid_d = 1'b1;
        end else begin
          cur_valid_d = 1'b0;
        end
`endif
        ptr_d   = ptr_q + 5'd1;
        state_d = S_WAIT;
        ret_d   = S_SCAN;
        cnt_d   = GAP;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = ret_q;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // bus writes land last so they override a same-cycle clear or DAT
    if (bus.clr_req) clr_pend_d = 1'b1;
    if (bus.wr_en) begin
      buf_d[bus.wr_addr]   = bus.wr_data;
      dirty_d[bus.wr_addr] = 1'b1;
    end

    set_cur_d = (state_d == S_CUR);
    set_dat_d = (state_d == S_DAT);
    clr_scr_d = (state_d == S_CLR);
    if (state_d == S_CUR) pos_d = ptr_q;
    // forward a write landing on the same edge so the sent value is never stale
    if (state_d == S_DAT)
      data_d = (bus.wr_en && (bus.wr_addr == ptr_q)) ? bus.wr_data : buf_q[ptr_q];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_SCAN;
      cnt_q      <= '0;
      ptr_q      <= 5'd0;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
      dirty_q    <= 32'd0;
      clr_pend_q <= 1'b0;
      pos_q      <= 5'd0;
      data_q     <= 8'h00;
      set_cur_q  <= 1'b0;
      set_dat_q  <= 1'b0;
      clr_scr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      dirty_q    <= dirty_d;
      clr_pend_q <= clr_pend_d;
      pos_q      <= pos_d;
      data_q     <= data_d;
      set_cur_q  <= set_cur_d;
      set_dat_q  <= set_dat_d;
      clr_scr_q  <= clr_scr_d;
    end
  end

`ifdef LCD1602_TEXT_BUF_SKIPCUR_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cur_pos_q   <= 5'd0;
      cur_valid_q <= 1'b0;
    end else begin
      cur_pos_q   <= cur_pos_d;
      cur_valid_q <= cur_valid_d;
    end
  end
`endif

  assign Pos        = pos_q;
  assign Data       = data_q;
  assign Set_Cursor = set_cur_q;
  assign Set_Data   = set_dat_q;
  assign Clr_Screen = clr_scr_q;
  assign bus.busy   = (state_q != S_IDLE) || clr_pend_q || (|dirty_q);
endmodule
